// File: rtl/dcache_ctrl_nway_if.sv
// Handshake bundle for dcache_ctrl_nway: datapath requests, memory strobes, flush scan and halt.
// The slave modport is the controller; the master modport is the datapath/memory side.
interface dcache_ctrl_nway_if #(
   parameter int WAYS     = 2,
   parameter int SETS     = 8,
   parameter int BLKWORDS = 2,
   parameter int CTW      = 32
);
   localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int SETW = $clog2(SETS);
   localparam int OFFW = $clog2(BLKWORDS);

   logic            dmemREN;
   logic            dmemWEN;
   logic            dhit;
   logic            flush;
   logic            dwait;
   logic            victim_dirty;
   logic            scan_dirty;
   logic            dREN;
   logic            dWEN;
   logic [OFFW-1:0] word_off;
   logic            fill_we;
   logic            wb_sel;
   logic            scan_mode;
   logic [SETW-1:0] scan_set;
   logic [WAYW-1:0] scan_way;
   logic            clean;
   logic            ct_store;
   logic [CTW-1:0]  hit_count;
   logic            halt;

   modport slave (
      input  dmemREN, dmemWEN, dhit, flush, dwait, victim_dirty, scan_dirty,
      output dREN, dWEN, word_off, fill_we, wb_sel, scan_mode, scan_set, scan_way,
             clean, ct_store, hit_count, halt
   );

   modport master (
      output dmemREN, dmemWEN, dhit, flush, dwait, victim_dirty, scan_dirty,
      input  dREN, dWEN, word_off, fill_we, wb_sel, scan_mode, scan_set, scan_way,
             clean, ct_store, hit_count, halt
   );
endinterface

// File: rtl/dcache_ctrl_nway.sv
// N-way data-cache control: miss writeback/fill, halt-time flush scan, sticky halt.
// Define DCACHE_HITCT_EN to build the hit counter and the CTSTORE state.
//
// state     | meaning
// IDLE      | serve hits, detect miss or flush
// WB        | write dirty victim block to memory
// FILL      | read missing block into victim way
// FLUSH_CHK | inspect one (set, way) entry per cycle
// FLUSH_WB  | write back dirty scanned entry
// CTSTORE   | store hit_count to memory (DCACHE_HITCT_EN only)
// HALT      | sticky halt until reset
module dcache_ctrl_nway #(
   parameter int WAYS     = 2,
   parameter int SETS     = 8,
   parameter int BLKWORDS = 2,
   parameter int CTW      = 32
) (
   input logic                 CLK,
   input logic                 nRST,
   dcache_ctrl_nway_if.slave   bus
);
   localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int SETW = $clog2(SETS);
   localparam int OFFW = $clog2(BLKWORDS);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WB        = 3'd1;
   localparam logic [2:0] FILL      = 3'd2;
   localparam logic [2:0] FLUSH_CHK = 3'd3;
   localparam logic [2:0] FLUSH_WB  = 3'd4;
   localparam logic [2:0] HALT      = 3'd6;
`ifdef DCACHE_HITCT_EN
   localparam logic [2:0] CTSTORE   = 3'd5;
   localparam logic [2:0] DONE      = CTSTORE;
`else
   localparam logic [2:0] DONE      = HALT;
`endif

   logic [2:0]      r_state, w_next;
   logic [OFFW-1:0] r_word, w_word_next;
   logic [SETW-1:0] r_set;
   logic [WAYW-1:0] r_way;
   logic            w_access, w_last_word, w_last_entry;
   logic            w_scan_adv, w_scan_clr, w_clean, w_fill_we;

   assign w_access     = bus.dmemREN | bus.dmemWEN;
   assign w_last_word  = (r_word == OFFW'(BLKWORDS - 1));
   assign w_last_entry = (r_set == SETW'(SETS - 1)) && (r_way == WAYW'(WAYS - 1));

   always_comb begin
      w_next      = r_state;
      w_word_next = r_word;
      w_scan_adv  = 1'b0;
      w_scan_clr  = 1'b0;
      w_clean     = 1'b0;
      w_fill_we   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access && !bus.dhit) begin
               w_next = bus.victim_dirty ? WB : FILL;
            end else if (bus.flush) begin
               w_next     = FLUSH_CHK;
               w_scan_clr = 1'b1;
            end
         end
         WB, FILL: begin
            w_fill_we = (r_state == FILL) && !bus.dwait;
            if (!bus.dwait) begin
               if (w_last_word) begin
                  w_word_next = '0;
                  w_next      = (r_state == WB) ? FILL : IDLE;
               end else begin
                  w_word_next = r_word + OFFW'(1);
               end
            end
         end
         FLUSH_CHK: begin
            if (bus.scan_dirty) begin
               w_next = FLUSH_WB;
            end else begin
               w_clean    = 1'b1;
               w_scan_adv = 1'b1;
               if (w_last_entry) w_next = DONE;
            end
         end
         FLUSH_WB: begin
            if (!bus.dwait) begin
               if (w_last_word) begin
                  w_word_next = '0;
                  w_clean     = 1'b1;
                  w_scan_adv  = 1'b1;
                  w_next      = w_last_entry ? DONE : FLUSH_CHK;
               end else begin
                  w_word_next = r_word + OFFW'(1);
               end
            end
         end
`ifdef DCACHE_HITCT_EN
         CTSTORE: if (!bus.dwait) w_next = HALT;
`endif
         HALT: w_next = HALT;
         default: w_next = IDLE;
      endcase
   end

   // Scan index is {set, way} with way least significant; wraps to 0 after the last entry.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_word  <= '0;
         r_set   <= '0;
         r_way   <= '0;
      end else begin
         r_state <= w_next;
         r_word  <= w_word_next;
         if (w_scan_clr) begin
            r_set <= '0;
            r_way <= '0;
         end else if (w_scan_adv) begin
            if (r_way == WAYW'(WAYS - 1)) begin
               r_way <= '0;
               r_set <= r_set + SETW'(1);
            end else begin
               r_way <= r_way + WAYW'(1);
            end
         end
      end
   end

`ifdef DCACHE_HITCT_EN
   // A miss decrements so that the retry hit after the fill nets to zero.
   logic [CTW-1:0] r_hit_count;
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         r_hit_count <= '0;
      else if (r_state == IDLE && w_access)
         r_hit_count <= bus.dhit ? r_hit_count + CTW'(1) : r_hit_count - CTW'(1);
   end
   assign bus.hit_count = r_hit_count;
   assign bus.ct_store  = (r_state == CTSTORE);
`else
   assign bus.hit_count = {CTW{1'b0}};
   assign bus.ct_store  = 1'b0;
`endif

   assign bus.dREN      = (r_state == FILL);
   assign bus.dWEN      = (r_state == WB) || (r_state == FLUSH_WB) || bus.ct_store;
   assign bus.word_off  = r_word;
   assign bus.fill_we   = w_fill_we;
   assign bus.wb_sel    = (r_state == WB);
   assign bus.scan_mode = (r_state == FLUSH_CHK) || (r_state == FLUSH_WB);
   assign bus.scan_set  = r_set;
   assign bus.scan_way  = r_way;
   assign bus.clean     = w_clean;
   assign bus.halt      = (r_state == HALT);
endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Self-checking bench for dcache_ctrl_nway: vector table, directed corner sequences,
// and randomized miss/hit traffic checked against a transaction-level model.
module tb_dcache_ctrl_nway;
`ifdef DCACHE_HITCT_EN
   localparam bit HITCT = 1'b1;
`else
   localparam bit HITCT = 1'b0;
`endif

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   dcache_ctrl_nway_if #(.WAYS(2), .SETS(8), .BLKWORDS(2), .CTW(32)) bus2 ();
   dcache_ctrl_nway_if #(.WAYS(2), .SETS(8), .BLKWORDS(4), .CTW(32)) bus4 ();

   dcache_ctrl_nway #(.WAYS(2), .SETS(8), .BLKWORDS(2), .CTW(32)) u_dut2 (
      .CLK(CLK), .nRST(nRST), .bus(bus2));
   dcache_ctrl_nway #(.WAYS(2), .SETS(8), .BLKWORDS(4), .CTW(32)) u_dut4 (
      .CLK(CLK), .nRST(nRST), .bus(bus4));

   // Dirty bits of the small DUT's cache, indexed {set, way}.
   logic [15:0] dirty_map;
   assign bus2.scan_dirty = dirty_map[{bus2.scan_set, bus2.scan_way}];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       ren, wen, hit, vdirty, flush;
      logic [3:0] exp;   // {dREN, dWEN, wb_sel, scan_mode} one cycle later
      string      name;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] hc_exp(input int m);
      return HITCT ? 32'(m) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus2.dmemREN = 0; bus2.dmemWEN = 0; bus2.dhit = 0; bus2.flush = 0;
      bus2.dwait = 0; bus2.victim_dirty = 0;
      bus4.dmemREN = 0; bus4.dmemWEN = 0; bus4.dhit = 0; bus4.flush = 0;
      bus4.dwait = 0; bus4.victim_dirty = 0; bus4.scan_dirty = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      dirty_map = '0;
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
   endtask

   function automatic logic [63:0] outs2();
      return 64'({bus2.dREN, bus2.dWEN, bus2.word_off, bus2.fill_we, bus2.wb_sel, bus2.scan_mode,
                  bus2.scan_set, bus2.scan_way, bus2.clean, bus2.ct_store, bus2.halt, bus2.hit_count});
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      bus2.dwait = 1'b0;
      while ((bus2.dREN || bus2.dWEN) && n < budget) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, 64'(n >= budget), 64'd0);
   endtask

   task automatic do_hits(input int n);
      for (int i = 0; i < n; i++) begin
         bus2.dmemREN = 1'b1; bus2.dhit = 1'b1;
         tick();
      end
      bus2.dmemREN = 1'b0; bus2.dhit = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 0, 0, 0, 0, 4'b0000, "idle"};
      vecs[1] = '{1, 0, 1, 0, 0, 4'b0000, "read_hit"};
      vecs[2] = '{1, 0, 0, 0, 0, 4'b1000, "read_miss_clean"};
      vecs[3] = '{0, 1, 0, 1, 0, 4'b0110, "write_miss_dirty"};
      vecs[4] = '{1, 0, 0, 1, 0, 4'b0110, "read_miss_dirty"};
      vecs[5] = '{0, 0, 0, 0, 1, 4'b0001, "flush"};
      vecs[6] = '{1, 0, 0, 0, 1, 4'b1000, "miss_over_flush"};
      vecs[7] = '{0, 1, 0, 1, 1, 4'b0110, "dirty_miss_over_flush"};
      vecs[8] = '{1, 0, 1, 0, 1, 4'b0001, "hit_and_flush"};
      vecs[9] = '{0, 1, 1, 1, 0, 4'b0000, "hit_ignores_victim"};

      // Reset state
      do_reset();
      check("reset_outs2", outs2(), 64'd0);
      check("reset_outs4", 64'({bus4.dREN, bus4.dWEN, bus4.word_off, bus4.scan_mode, bus4.halt}), 64'd0);

      // Table of single-cycle IDLE decisions
      foreach (vecs[i]) begin
         do_reset();
         bus2.dmemREN = vecs[i].ren; bus2.dmemWEN = vecs[i].wen; bus2.dhit = vecs[i].hit;
         bus2.victim_dirty = vecs[i].vdirty; bus2.flush = vecs[i].flush; bus2.dwait = 1'b1;
         tick();
         bus2.dmemREN = 0; bus2.dmemWEN = 0; bus2.dhit = 0; bus2.flush = 0;
         check({"vec_", vecs[i].name},
               64'({bus2.dREN, bus2.dWEN, bus2.wb_sel, bus2.scan_mode}), 64'(vecs[i].exp));
      end

      // Clean read miss, two wait cycles per word
      begin
         int ren_n = 0, pulses = 0;
         int offs[$];
         do_reset();
         bus2.dmemREN = 1'b1; bus2.dwait = 1'b1;
         tick();
         bus2.dmemREN = 1'b0;
         for (int k = 0; k < 20; k++) begin
            bus2.dwait = (k % 3 != 2);
            #1;
            if (!bus2.dREN) break;
            ren_n++;
            if (bus2.fill_we) begin
               pulses++;
               offs.push_back(int'(bus2.word_off));
            end
            tick();
         end
         check("clean_miss_dren_cycles", 64'(ren_n), 64'd6);
         check("clean_miss_fill_pulses", 64'(pulses), 64'd2);
         check("clean_miss_off0", 64'(offs.size() > 0 ? offs[0] : -1), 64'd0);
         check("clean_miss_off1", 64'(offs.size() > 1 ? offs[1] : -1), 64'd1);
         check("clean_miss_idle", 64'({bus2.dREN, bus2.dWEN, bus2.scan_mode}), 64'd0);
         check("clean_miss_hitct", 64'(bus2.hit_count), 64'(hc_exp(-1)));
      end

      // Dirty victim miss on the 4-word DUT, no wait states
      do_reset();
      bus4.dmemWEN = 1'b1; bus4.victim_dirty = 1'b1;
      tick();
      bus4.dmemWEN = 1'b0;
      for (int c = 0; c < 9; c++) begin
         int e;
         e = (c < 4) ? (4 + c) : (c < 8) ? (8 + c - 4) : 0;
         check($sformatf("dirty_burst_c%0d", c),
               64'({bus4.dREN, bus4.dWEN, bus4.word_off}), 64'(e));
         tick();
      end

      // Five hits, a miss, then the retry hit
      do_reset();
      do_hits(5);
      bus2.dmemREN = 1'b1; bus2.dhit = 1'b0;
      tick();
      bus2.dmemREN = 1'b0;
      wait_idle("hits_miss_fill", 20);
      do_hits(1);
      check("hits_miss_retry_hitct", 64'(bus2.hit_count), 64'(hc_exp(5)));

      // Flush with dirty entries at (3,1) and (7,1)
      begin
         int chk_n = 0, wb_n = 0, clean_n = 0, ct_n = 0, order_bad = 0, halt_bad = 0;
         logic [31:0] ct_val = '0;
         int wb_list[$];
         do_reset();
         do_hits(3);
         dirty_map[3*2+1] = 1'b1;
         dirty_map[7*2+1] = 1'b1;
         bus2.flush = 1'b1;
         tick();
         bus2.flush = 1'b0;
         for (int c = 0; c < 300 && !bus2.halt; c++) begin
            if (bus2.scan_mode && !bus2.dWEN) begin
               if (int'({bus2.scan_set, bus2.scan_way}) != chk_n) order_bad++;
               chk_n++;
            end
            if (bus2.scan_mode && bus2.dWEN) begin
               wb_n++;
               if (bus2.word_off == 1'b0) wb_list.push_back(int'({bus2.scan_set, bus2.scan_way}));
            end
            if (bus2.clean) clean_n++;
            if (bus2.ct_store) begin
               ct_n++;
               ct_val = bus2.hit_count;
               if (!bus2.dWEN) order_bad++;
            end
            tick();
         end
         check("flush_halt", 64'(bus2.halt), 64'd1);
         check("flush_scan_cycles", 64'(chk_n), 64'd16);
         check("flush_wb_cycles", 64'(wb_n), 64'd4);
         check("flush_clean_pulses", 64'(clean_n), 64'd16);
         check("flush_scan_order", 64'(order_bad), 64'd0);
         check("flush_wb_entry0", 64'(wb_list.size() > 0 ? wb_list[0] : -1), 64'd7);
         check("flush_wb_entry1", 64'(wb_list.size() > 1 ? wb_list[1] : -1), 64'd15);
         check("flush_ctstore_cycles", 64'(ct_n), 64'(HITCT ? 1 : 0));
         check("flush_ctstore_value", 64'(ct_val), 64'(hc_exp(3)));
         for (int c = 0; c < 100; c++) begin
            bus2.flush = 1'($urandom_range(0, 1)); bus2.dmemREN = 1'($urandom_range(0, 1));
            bus2.dmemWEN = 1'($urandom_range(0, 1)); bus2.dhit = 1'($urandom_range(0, 1));
            bus2.dwait = 1'($urandom_range(0, 1));
            #1;
            if (!bus2.halt || bus2.dREN || bus2.dWEN) halt_bad++;
            tick();
         end
         idle_inputs();
         check("halt_sticky_bad_cycles", 64'(halt_bad), 64'd0);
      end

      // Flush and miss together, flush held high
      do_reset();
      bus2.dmemREN = 1'b1; bus2.flush = 1'b1;
      tick();
      bus2.dmemREN = 1'b0;
      check("flushmiss_miss_first", 64'({bus2.dREN, bus2.scan_mode}), 64'b10);
      tick();
      tick();
      check("flushmiss_idle_gap", 64'({bus2.dREN, bus2.dWEN, bus2.scan_mode}), 64'd0);
      tick();
      check("flushmiss_flush_starts", 64'({bus2.scan_mode, bus2.dWEN}), 64'b10);
      bus2.flush = 1'b0;

      // Reset pulse during WB word 1
      do_reset();
      do_hits(2);
      bus2.dmemWEN = 1'b1; bus2.victim_dirty = 1'b1;
      tick();
      bus2.dmemWEN = 1'b0;
      tick();
      bus2.dwait = 1'b1;
      #1;
      check("rst_mid_pre", 64'({bus2.dWEN, bus2.word_off}), 64'b11);
      nRST = 1'b0;
      #1;
      check("rst_mid_async", 64'({bus2.dREN, bus2.dWEN, bus2.word_off, bus2.hit_count}), 64'd0);
      #3;
      nRST = 1'b1;
      tick();
      check("rst_mid_after", outs2(), 64'd0);
      idle_inputs();

      // Randomized traffic against a transaction-level model
      begin
         int hc_model = 0;
         int exp_q[$];
         int obs_q[$];
         do_reset();
         for (int op_i = 0; op_i < 40; op_i++) begin
            int op, mism, n;
            bit rw;
            op = $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            exp_q.delete();
            obs_q.delete();
            bus2.dmemREN = rw; bus2.dmemWEN = !rw;
            bus2.dhit = (op < 2);
            bus2.victim_dirty = (op == 3) ? 1'b1 : (op == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (op < 2) hc_model++;
            else hc_model--;
            if (op == 3) for (int w = 0; w < 2; w++) exp_q.push_back(16 + w);
            if (op >= 2) for (int w = 0; w < 2; w++) exp_q.push_back(w);
            tick();
            bus2.dmemREN = 0; bus2.dmemWEN = 0; bus2.dhit = 0;
            mism = 0;
            n = 0;
            while (n < 100) begin
               bus2.dwait = 1'($urandom_range(0, 1));
               #1;
               if (!bus2.dREN && !bus2.dWEN) break;
               if (bus2.dREN && bus2.dWEN) mism++;
               if (bus2.fill_we !== (bus2.dREN && !bus2.dwait)) mism++;
               if (!bus2.dwait) obs_q.push_back((bus2.dWEN ? 16 : 0) + int'(bus2.word_off));
               tick();
               n++;
            end
            if (n >= 100) mism++;
            if (obs_q.size() != exp_q.size()) mism++;
            else foreach (exp_q[j]) if (obs_q[j] != exp_q[j]) mism++;
            check($sformatf("rand_xfer_op%0d", op_i), 64'(mism), 64'd0);
            check($sformatf("rand_hitct_op%0d", op_i), 64'(bus2.hit_count), 64'(hc_exp(hc_model)));
         end
         idle_inputs();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl_nway.md
Name: dcache_ctrl_nway

Overview:
- Parametrised N-way, multi-word-block data-cache control unit; next generation of the 2-way, 2-word dcache controller.
- Sequences miss handling (victim writeback, then block fill) and the halt-time flush, which walks every set and way.
- Maintains a signed hit counter and stores it to memory before asserting a sticky halt.
- Sits between datapath-facing cache arrays (tags, data, dirty, LRU) and the memory-side dREN/dWEN/dwait handshake.

Parameters:
- WAYS, 2, associativity (power of 2, >=1); WAYW = max(1, clog2(WAYS)).
- SETS, 8, sets per way (power of 2, >=2); SETW = clog2(SETS).
- BLKWORDS, 2, words per block (power of 2, >=2); OFFW = clog2(BLKWORDS).
- CTW, 32, hit-counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- dhit  in  1  tag match in indexed set, any way
- flush  in  1  halt request from datapath
- dwait  in  1  memory busy; transfer completes on a cycle with dwait=0
- victim_dirty  in  1  dirty bit of the LRU-selected way in the indexed set
- scan_dirty  in  1  dirty bit of entry (scan_set, scan_way)
- dREN  out  1  memory read
- dWEN  out  1  memory write
- word_off  out  OFFW  word offset of current transfer
- fill_we  out  1  write returned word into victim way
- wb_sel  out  1  1 = address/data from victim (WB), 0 = missing address (FILL)
- scan_mode  out  1  cache index taken from scan_set/scan_way
- scan_set  out  SETW  flush scan set
- scan_way  out  WAYW  flush scan way
- clean  out  1  clear valid and dirty of scanned entry this cycle
- ct_store  out  1  drive hit_count onto memory data, address 0x3100
- hit_count  out  CTW  signed hit counter
- halt  out  1  processor halt, sticky

Behaviour:
- Clock and reset: async active-low nRST on CLK. Reset puts state in IDLE and clears word counter, scan index and hit_count; all outputs are 0.
- Reset asserted mid-transfer aborts the transfer immediately, with no further memory strobes.
- IDLE:
  - access = dmemREN|dmemWEN.
  - access & ~dhit: go to WB if victim_dirty, else FILL.
  - Else if flush: go to FLUSH_CHK with scan index 0.
  - A miss takes priority over flush in the same cycle.
  - access & dhit: hit_count += 1.
  - IDLE->miss transition: hit_count -= 1, so a miss-then-retry-hit nets 0.
- WB:
  - dWEN=1, wb_sel=1, word_off = word counter.
  - Each dwait=0 cycle advances the counter.
  - On the word BLKWORDS-1 completion: counter resets to 0 and state goes to FILL.
- FILL:
  - dREN=1, wb_sel=0, fill_we = ~dwait.
  - Counter advances as in WB.
  - After the last word: go to IDLE. The datapath retries and hits.
- FLUSH_CHK:
  - scan_mode=1; one cycle per entry.
  - scan_dirty: go to FLUSH_WB.
  - Else clean=1 and the index advances.
  - Index is {set, way}, way least significant.
  - At the last entry (index SETS*WAYS-1) with no writeback needed: go to CTSTORE.
- FLUSH_WB:
  - dWEN=1, scan_mode=1, word counter as in WB.
  - On last-word completion: clean=1 for that entry; the index advances and state returns to FLUSH_CHK, or goes to CTSTORE if it was the last entry.
- CTSTORE:
  - dWEN=1, ct_store=1.
  - On dwait=0: go to HALT.
  - hit_count is frozen from flush entry onward.
- HALT: halt=1 and the state is held until nRST. flush/access are ignored.
- Arithmetic: hit_count is two's complement and wraps modulo 2^CTW. Word counter and scan index wrap to 0 on completion.
- dREN and dWEN are never both 1. Outputs are Moore except fill_we and clean.

Optional Feature:
- DCACHE_HITCT_EN defined: hit_count and the CTSTORE state exist as described.
- Undefined: hit_count tied to 0, ct_store tied to 0, CTSTORE removed; flush completion goes directly to HALT.

Test Plan:
- WAYS=2, BLKWORDS=2, clean miss on a read, dwait=1 for 2 cycles per word -> FILL only; dREN held 6 cycles, word_off 0 then 1, fill_we pulses twice, then IDLE; hit_count = -1.
- Dirty victim miss, BLKWORDS=4, dwait=0 -> dWEN 4 cycles (word_off 0..3), then dREN 4 cycles; no gap cycles.
- 5 hits, then 1 miss, then retry hit -> hit_count = 5. With the macro off -> hit_count = 0.
- SETS=8, WAYS=2, dirty entries at set 3 way 1 and set 7 way 1, flush asserted -> 16 scan cycles plus 2 writebacks; CTSTORE writes hit_count to 0x3100; halt=1 and stays 1 for 100 cycles.
- flush and miss asserted in the same cycle -> miss sequence first; flush begins on the next IDLE cycle with flush still high.
- nRST pulsed during WB word 1 -> state IDLE, dWEN=0 asynchronously, hit_count = 0, word_off = 0 after release.
